// File: rtl/nand_vector_sequencer.sv
// Stimulus/checker for the multi-input NAND gate block: steps through a vector set,
// waits a settle window, compares the six gate outputs and accumulates error statistics.
module nand_vector_sequencer #(
  parameter int SETTLE = 4,
  parameter int ERR_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  output logic [13:0]      stim_o,
  input  logic [5:0]       resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [13:0]      fail_idx_o,
  output logic [5:0]       fail_resp_o
);

  // state    | meaning
  // S_IDLE   | waiting for start, outputs hold last run's results
  // S_DRIVE  | apply vector(k), load settle timer
  // S_SETTLE | count settle timer down to zero
  // S_SAMPLE | compare response, update stats, advance k
  // S_FINISH | one-cycle done pulse, back to idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  localparam logic [7:0]       SETTLE_L = 8'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [13:0]        k_q, k_d;
  logic               mode_q, mode_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [13:0]        stim_q, stim_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [13:0]        fail_idx_q, fail_idx_d;
  logic [5:0]         fail_resp_q, fail_resp_d;
  logic               pass_q, pass_d;
  logic               last_vec;

  function automatic logic [5:0] expect_resp(input logic [13:0] s);
    logic [5:0] y;
    y[0] = ~&s[1:0];
    y[1] = ~&s[2:0];
    y[2] = ~&s[3:0];
    y[3] = ~&s[7:0];
    y[4] = s[13] ? ~&s[11:0] : 1'b1;  // OC low releases Y4, which then reads high
    y[5] = ~&s[12:0];
    return y;
  endfunction

  function automatic logic [13:0] vec_of(input logic mode, input logic [13:0] k);
    logic [13:0] v;
    if (mode) begin
      v = k;
    end else begin
      v = '0;
      for (int i = 0; i < 13; i++) v[i] = (i < int'(k));
      v[13] = (k != 14'd14);
    end
    return v;
  endfunction

  assign last_vec = mode_q ? (k_q == 14'h3FFF) : (k_q == 14'd14);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    err_d       = err_q;
    fail_idx_d  = fail_idx_q;
    fail_resp_d = fail_resp_q;
    pass_d      = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_DRIVE;
          k_d         = '0;
          mode_d      = mode_i;
          err_d       = '0;
          fail_idx_d  = '0;
          fail_resp_d = '0;
          pass_d      = 1'b0;
        end
      end
      S_DRIVE: begin
        stim_d  = vec_of(mode_q, k_q);
        cnt_d   = SETTLE_L;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (resp_i != expect_resp(stim_q)) begin
          if (err_q != '1) err_d = err_q + ERR_ONE;
          if (err_q == '0) begin
            fail_idx_d  = k_q;
            fail_resp_d = resp_i;
          end
        end
        if (last_vec) begin
          state_d = S_FINISH;
          pass_d  = (err_d == '0);  // includes this vector's result
        end else begin
          k_d     = k_q + 14'd1;
          state_d = S_DRIVE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      stim_q      <= 14'h2000;
      err_q       <= '0;
      fail_idx_q  <= '0;
      fail_resp_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      err_q       <= err_d;
      fail_idx_q  <= fail_idx_d;
      fail_resp_q <= fail_resp_d;
      pass_q      <= pass_d;
    end
  end

  assign stim_o      = stim_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FINISH);
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_q;
  assign fail_idx_o  = fail_idx_q;
  assign fail_resp_o = fail_resp_q;

endmodule
